// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: RV32I load/store funct3 codes and the
// controller state encoding.
package dcache_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StRespond
  } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// Core-side request/response channel of the data cache; the pipeline memory
// stage is the master and holds req until resp.
interface dcache_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        resp;

  modport master (output req, we, addr, wdata, funct3, input rdata, resp);
  modport slave  (input req, we, addr, wdata, funct3, output rdata, resp);
endinterface

// File: rtl/dcache_data_align.sv
// Combinational byte-lane handling: load extraction with sign/zero extension and
// store merging of a byte/half/word into an existing cache word.
module dcache_data_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] rdata_ext
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    // Halves ignore off[0] so the access is force-aligned.
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_LH:   rdata_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LBU:  rdata_ext = {24'h0, byte_sh[7:0]};
      F3_LHU:  rdata_ext = {16'h0, half_sh[15:0]};
      default: rdata_ext = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_SB:   merged[{off, 3'b000} +: 8] = wdata[7:0];
      F3_SH:   merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete from local
// arrays; misses write back a dirty victim and refill over a word-serial port.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     core,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF_W  = 2 + WORD_W;
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;

  dcache_state_t state_q, state_d;

  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic [WORD_W-1:0] cnt_q;
  logic              gap_q;
  logic              after_resp_q;
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS*LINE_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] word;
  logic              hit;
  logic              cnt_last;
  logic              xfer;
  logic [31:0]       merged;
  logic [31:0]       load_ext;

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[31 -: TAG_W];
  assign word     = addr_q[2 +: WORD_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign cnt_last = (cnt_q == WORD_W'(LINE_WORDS - 1));
  assign xfer     = mem_req && mem_ready;
  assign core.rdata = rdata_q;

  dcache_data_align u_align (
    .word      (data_q[{idx, word}]),
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .merged    (merged),
    .rdata_ext (load_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (core.req && !after_resp_q) state_d = StLookup;
      StLookup: begin
        if (hit)               state_d = StRespond;
        else if (dirty_q[idx]) state_d = StWriteback;
        else                   state_d = StRefill;
      end
      StWriteback: if (xfer && cnt_last) state_d = StRefill;
      StRefill:    if (xfer && cnt_last) state_d = StLookup;
      StRespond:   state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    core.resp = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx, cnt_q, 2'b00};
        mem_wdata = data_q[{idx, cnt_q}];
      end
      StRefill: begin
        // First refill cycle after a write-back is an idle gap on the port.
        mem_req  = !gap_q;
        mem_addr = {tag, idx, cnt_q, 2'b00};
      end
      StRespond: core.resp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= 1'b0;
      after_resp_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      after_resp_q <= (state_q == StRespond);
      gap_q        <= (state_q == StWriteback) && xfer && cnt_last;
      if (state_q == StIdle && core.req && !after_resp_q) begin
        we_q    <= core.we;
        addr_q  <= core.addr;
        wdata_q <= core.wdata;
        f3_q    <= core.funct3;
      end
      if (xfer) cnt_q <= cnt_last ? '0 : cnt_q + WORD_W'(1);
      if (state_q == StLookup) begin
        if (hit) begin
          if (we_q) dirty_q[idx] <= 1'b1;
          else      rdata_q      <= load_ext;
        end else begin
          // Line is being replaced; keep it invalid until the refill completes.
          valid_q[idx] <= 1'b0;
        end
      end
      if (state_q == StRefill && xfer && cnt_last) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StLookup && hit && we_q) data_q[{idx, word}] <= merged;
    if (state_q == StRefill && xfer)        data_q[{idx, cnt_q}] <= mem_rdata;
    if (state_q == StRefill && xfer && cnt_last) tag_q[idx] <= tag;
  end

endmodule
